// File: rtl/ps2_scan_decoder.sv
// PS/2 scan-code decoder: folds E0/F0 prefix bytes into single key events
// with a valid/ready handshake, and tracks the held key and a release count.
// Optional build macro PS2_TYPEMATIC_FILTER_EN suppresses typematic repeat
// make events of the key already held down.
module ps2_scan_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_break,
  output logic             evt_ext,
  output logic             key_down,
  output logic [7:0]       cur_code,
  output logic [CNT_W-1:0] key_count,
  output logic             err
);

  localparam logic [7:0] CODE_EXT  = 8'hE0;
  localparam logic [7:0] CODE_BRK  = 8'hF0;
  localparam logic [7:0] CODE_NUL  = 8'h00;
  localparam logic [7:0] CODE_OVR  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } state_t;

  state_t state;
  state_t state_next;

  logic accept;
  logic emit;
  logic emit_break;
  logic emit_ext;
  logic emit_evt;
  logic err_next;
  logic held_ext;
  logic break_match;

  // A new byte may enter whenever the event slot is empty or being drained.
  assign in_ready = !evt_valid || evt_ready;
  assign accept   = in_valid && in_ready;

  // A release only clears key_down when it names the exact key being held.
  assign break_match = (in_data == cur_code) && (emit_ext == held_ext);

`ifdef PS2_TYPEMATIC_FILTER_EN
  // Repeat makes of the held key update key state but produce no event.
  assign emit_evt = emit && !(!emit_break && key_down &&
                              (in_data == cur_code) && (emit_ext == held_ext));
`else
  assign emit_evt = emit;
`endif

  // Prefix state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Prefix decoding: decides the next prefix state, whether an event completes, and errors.
  always_comb begin
    state_next = state;
    emit       = 1'b0;
    emit_break = 1'b0;
    emit_ext   = 1'b0;
    err_next   = 1'b0;
    if (accept) begin
      if (in_data == CODE_NUL || in_data == CODE_OVR) begin
        state_next = IDLE;
        err_next   = 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (in_data == CODE_EXT) begin
              state_next = EXT;
            end else if (in_data == CODE_BRK) begin
              state_next = BRK;
            end else begin
              emit = 1'b1;
            end
          end
          EXT: begin
            if (in_data == CODE_BRK) begin
              state_next = EXT_BRK;
            end else if (in_data == CODE_EXT) begin
              err_next = 1'b1;
            end else begin
              emit       = 1'b1;
              emit_ext   = 1'b1;
              state_next = IDLE;
            end
          end
          BRK: begin
            if (in_data == CODE_BRK) begin
              err_next = 1'b1;
            end else if (in_data == CODE_EXT) begin
              state_next = EXT;
              err_next   = 1'b1;
            end else begin
              emit       = 1'b1;
              emit_break = 1'b1;
              state_next = IDLE;
            end
          end
          EXT_BRK: begin
            if (in_data == CODE_EXT || in_data == CODE_BRK) begin
              state_next = IDLE;
              err_next   = 1'b1;
            end else begin
              emit       = 1'b1;
              emit_break = 1'b1;
              emit_ext   = 1'b1;
              state_next = IDLE;
            end
          end
          default: state_next = IDLE;
        endcase
      end
    end
  end

  // Output event slot: loads on a new event, empties when consumed without a replacement.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      evt_valid <= 1'b0;
      evt_code  <= 8'h00;
      evt_break <= 1'b0;
      evt_ext   <= 1'b0;
    end else if (emit_evt) begin
      evt_valid <= 1'b1;
      evt_code  <= in_data;
      evt_break <= emit_break;
      evt_ext   <= emit_ext;
    end else if (evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

  // Held-key tracking, updated for every completed make/break even when filtered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_down <= 1'b0;
      cur_code <= 8'h00;
      held_ext <= 1'b0;
    end else if (emit) begin
      if (!emit_break) begin
        key_down <= 1'b1;
        cur_code <= in_data;
        held_ext <= emit_ext;
      end else if (break_match) begin
        key_down <= 1'b0;
      end
    end
  end

  // Release counter, wrapping naturally at its width.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_count <= '0;
    end else if (emit && emit_break) begin
      key_count <= key_count + CNT_W'(1);
    end
  end

  // Error pulse, one cycle per offending byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else begin
      err <= err_next;
    end
  end

endmodule

// File: doc/ps2_scan_decoder.md
PS2_SCAN_DECODER -- requirements
Module: ps2_scan_decoder

Interface
REQ-001 Parameter: CNT_W, default 8, width of key_count.
REQ-002 clock  input  1  single clock domain; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream PS/2 receiver presents a scan-code byte.
REQ-005 in_data  input  8  scan-code byte.
REQ-006 in_ready  output  1  decoder accepts byte this cycle.
REQ-007 evt_valid  output  1  key event pending.
REQ-008 evt_ready  input  1  downstream consumes event.
REQ-009 evt_code  output  8  key code, without E0/F0 prefixes.
REQ-010 evt_break  output  1  1 = release, 0 = press.
REQ-011 evt_ext  output  1  1 = E0-prefixed key.
REQ-012 key_down  output  1  a key is currently held.
REQ-013 cur_code  output  8  code of the most recently pressed key.
REQ-014 key_count  output  CNT_W  count of emitted release events.
REQ-015 err  output  1  one-cycle pulse on protocol error.

Function
REQ-016 A byte is accepted iff in_valid && in_ready; in_ready = !evt_valid || evt_ready (combinational).
REQ-017 FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
REQ-018 IDLE: E0->EXT; F0->BRK; other code->emit make (ext=0), stay IDLE.
REQ-019 EXT: F0->EXT_BRK; E0->EXT, err pulse; other->emit make (ext=1), ->IDLE.
REQ-020 BRK: code->emit break (ext=0), ->IDLE; F0->BRK, err pulse; E0->EXT, err pulse.
REQ-021 EXT_BRK: code->emit break (ext=1), ->IDLE; E0/F0->IDLE, err pulse.
REQ-022 Bytes 0x00 and 0xFF (receiver overrun/error) in any state->IDLE, err pulse, no event.
REQ-023 Emit latency: evt_valid rises the cycle after the final byte is accepted; evt_code/break/ext stable while evt_valid && !evt_ready.
REQ-024 evt_valid clears the cycle after evt_valid && evt_ready unless a new event is emitted in that same handshake cycle, in which case it stays high with the new fields.
REQ-025 On a make event: cur_code <= code, key_down <= 1, held-ext flag <= ext.
REQ-026 On a break event whose code and ext match cur_code/held-ext: key_down <= 0; a non-matching break leaves key_down and cur_code unchanged.
REQ-027 key_count increments by 1 on each emitted break event; wraps 2^CNT_W-1 -> 0.
REQ-028 err is registered and asserted for exactly one cycle per error byte.

Reset
REQ-029 reset asserted: FSM->IDLE, evt_valid=0, evt_code=0, evt_break=0, evt_ext=0, key_down=0, cur_code=0, key_count=0, err=0, immediately and independent of clock.
REQ-030 reset mid-sequence (e.g. after E0 F0) discards the partial prefix; no event is emitted after release.
REQ-031 in_ready is 1 during and after reset (evt_valid=0).

Configuration
REQ-032 Macro PS2_TYPEMATIC_FILTER_EN defined: a make event with the same code and ext as the held key while key_down=1 is suppressed (no evt_valid), while FSM and key state still update.
REQ-033 Macro PS2_TYPEMATIC_FILTER_EN undefined: every make sequence emits an event, including typematic repeats.

Verification
REQ-034 Bytes 1C,F0,1C, evt_ready=1 -> events {1C,break=0,ext=0}, {1C,break=1,ext=0}; key_count=1; key_down 1 then 0.
REQ-035 Bytes E0,75,E0,F0,75 -> events {75,0,1}, {75,1,1}; key_count=1; err never asserted.
REQ-036 Bytes 1B,1B,1B,F0,1B with filter on -> 2 events (make, break); with filter off -> 4 events.
REQ-037 evt_ready=0 held for 5 cycles after event 1C -> in_ready=0, evt fields stable; next in_valid byte not accepted until evt_ready=1.
REQ-038 Bytes F0,E0,FF -> err pulses twice, FSM IDLE, no event; 256 F0/xx pairs -> key_count wraps to 0.
REQ-039 reset pulsed after E0,F0 then byte 1C -> single make event {1C,0,0}, key_count=0.
